ahb3_lite_regfile_slave: RTL and testbench
==========================================

Name: ahb3_lite_regfile_slave

Overview:
Parametrised AHB3-Lite register-file slave. It exposes NUM_REGS 32-bit registers with configurable wait states, byte/halfword/word lane writes, and full two-cycle ERROR responses. It sits behind the AHB3-Lite decoder/mux as a generic control/status slave. Its register contents are exported flat for use by peripheral logic.

Parameters:
ADDR_WIDTH, 32, width of haddr_i.
NUM_REGS, 8, number of 32-bit registers; a power of two, >= 2.
WAIT_STATES, 0, hreadyout_o low cycles inserted per OKAY data phase (0..15).

Ports:
clk_i  input  1  clock.
rst_n_i  input  1  asynchronous active-low reset.
haddr_i  input  ADDR_WIDTH  address.
hburst_i  input  3  burst type (informational only).
hsize_i  input  3  transfer size.
htrans_i  input  2  IDLE/BUSY/NONSEQ/SEQ.
hwdata_i  input  32  write data (data phase).
hwrite_i  input  1  1 = write.
hsel_i  input  1  slave select.
hready_i  input  1  bus HREADY from the mux.
hrdata_o  output  32  read data.
hreadyout_o  output  1  slave ready.
hresp_o  output  1  0 = OKAY, 1 = ERROR.
regs_o  output  NUM_REGS*32  register contents; reg k at bits [32k+31:32k].
wr_pulse_o  output  NUM_REGS  one-cycle pulse per register written.

Behaviour:
- Clock is clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: all registers 0, hrdata_o=0, hreadyout_o=1, hresp_o=0, wr_pulse_o=0, state S_IDLE.
- Accept condition: hsel_i && hready_i && htrans_i[1] (NONSEQ or SEQ).
  - On accept, capture address, hsize_i and hwrite_i.
  - IDLE and BUSY, and any cycle with hsel_i or hready_i low, are ignored and get a zero-wait OKAY.
- Decode: IDX_W = $clog2(NUM_REGS).
  - Register index = haddr_i[IDX_W+1:2].
  - Error if haddr_i[ADDR_WIDTH-1:IDX_W+2] != 0.
  - Error if hsize_i > WORD.
  - Error if misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- State machine (data phase):
  - S_IDLE: hreadyout_o=1, hresp_o=0.
    - Accept with error -> S_ERR1.
    - Accept OK with WAIT_STATES>0 -> S_WAIT (counter loaded with WAIT_STATES-1).
    - Accept OK with WAIT_STATES=0 -> S_DATA.
  - S_WAIT: hreadyout_o=0, hresp_o=0; counter decrements; at 0 -> S_DATA.
  - S_DATA: hreadyout_o=1, hresp_o=0; the data phase completes this cycle.
    - A new accept in the same cycle is legal (pipelined) and follows the S_IDLE rules.
    - With no accept -> S_IDLE.
  - S_ERR1: hreadyout_o=0, hresp_o=1 -> S_ERR2.
  - S_ERR2: hreadyout_o=1, hresp_o=1. Next state follows the S_IDLE rules; the master may cancel with IDLE.
- Write: committed at the clock edge ending S_DATA, using hwdata_i.
  - Byte lane: addr[1:0] selects bits [8a+7:8a].
  - Halfword: addr[1] selects [15:0] or [31:16].
  - Word: all 32 bits.
  - wr_pulse_o[idx] is high the cycle after commit.
  - An errored write changes nothing.
- Read: hrdata_o is combinational.
  - In S_DATA for a read: the full 32-bit register word (lanes not masked).
  - Otherwise 0.
  - A read whose data phase directly follows a write to the same register returns the new value.
- Bursts: each beat is treated as an independent accept. SEQ and NONSEQ are identical, so early termination and INCR of any length need no special handling. BUSY inserts an OKAY idle cycle.
- Reset mid-transfer (including in S_WAIT or S_ERR1): immediate return to the reset values; the pending write is dropped.

Decomposition:
- Shared package ahb3_lite_pkg holds:
  - HTRANS, HBURST and HSIZE constants;
  - the data-phase state enum (S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2);
  - the HRESP OKAY/ERROR constants.
- One sub-module, ahb3_lite_wstrb_gen: maps hsize + addr[1:0] to a 4-bit byte strobe plus a misalign flag. It is shared with future AHB slaves.

Test Plan:
- Word write 0xDEADBEEF to 0x0, then read 0x0 -> hrdata_o=0xDEADBEEF, hresp_o=0, wr_pulse_o[0] pulses once.
- Byte write at 0x5 with hwdata_i=0x0000AB00 onto reg1=0x11223344 -> reg1=0x1122AB44. Then halfword write 0xCAFE0000 at 0x6 -> reg1=0xCAFEAB44.
- NUM_REGS=8, write to 0x20 -> S_ERR1 (hreadyout_o=0, hresp_o=1) then S_ERR2 (1,1); all regs unchanged. Halfword at 0x1 -> the same error sequence.
- WAIT_STATES=2, back-to-back NONSEQ writes -> hreadyout_o low for exactly 2 cycles per beat; both writes land.
- WAIT_STATES=0, INCR4 burst writing 1,2,3,4 to 0x0..0xC, then pipelined read of 0x8 right after the last write -> regs 0..3 = 1..4, read returns 3 with no stalls.
- Assert rst_n_i during S_WAIT of a write -> outputs at reset values immediately; the target register stays 0.

Source files
------------

// File: rtl/ahb3_lite_pkg.sv
// Shared AHB3-Lite encodings and the data-phase state type used by the slaves.
package ahb3_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

endpackage

// File: rtl/ahb3_lite_wstrb_gen.sv
// Byte-strobe generator for 32-bit AHB slaves: transfer size plus low address
// bits give the active byte lanes and whether the access is misaligned.
module ahb3_lite_wstrb_gen
  import ahb3_lite_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misalign
);

  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb     = 4'b1111;
        misalign = |addr_lo;
      end
      default: begin
        strb     = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb3_lite_regfile_slave.sv
// AHB3-Lite register-file slave: NUM_REGS x 32-bit registers, optional wait
// states, byte/halfword/word writes and two-cycle ERROR responses.
module ahb3_lite_regfile_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [ADDR_WIDTH-1:0]    haddr_i,
  input  logic [2:0]               hburst_i,
  input  logic [2:0]               hsize_i,
  input  logic [1:0]               htrans_i,
  input  logic [31:0]              hwdata_i,
  input  logic                     hwrite_i,
  input  logic                     hsel_i,
  input  logic                     hready_i,
  output logic [31:0]              hrdata_o,
  output logic                     hreadyout_o,
  output logic                     hresp_o,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);
  import ahb3_lite_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               write_q;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         strb_q;
  logic [31:0]        regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_d;

  logic       can_take, take, req_err, commit;
  logic [3:0] strb_w;
  logic       misalign_w;

  // Burst type and the SEQ/NONSEQ distinction carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{hburst_i, htrans_i[0]};

  ahb3_lite_wstrb_gen u_wstrb (
    .hsize    (hsize_i),
    .addr_lo  (haddr_i[1:0]),
    .strb     (strb_w),
    .misalign (misalign_w)
  );

  assign can_take = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign take     = can_take && hsel_i && hready_i && htrans_i[1];
  assign req_err  = (|haddr_i[ADDR_WIDTH-1:IDX_W+2]) || (hsize_i > HSIZE_WORD) || misalign_w;
  assign commit   = (state_q == S_DATA) && write_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) write_q <= hwrite_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (take) begin
      idx_q  <= haddr_i[IDX_W+1:2];
      strb_q <= strb_w;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (state_q == S_ERR2) hresp_o = HRESP_ERROR;
        state_d = S_IDLE;
        if (take) begin
          if (req_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_WAIT: begin
        hreadyout_o = 1'b0;
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = S_ERR2;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pulse_d = '0;
    for (int k = 0; k < NUM_REGS; k++)
      pulse_d[k] = commit && (idx_q == IDX_W'(k));
  end

  // Write data arrives in the data phase, so lanes are merged at the edge ending S_DATA.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 32'd0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= pulse_d;
      if (commit) begin
        for (int b = 0; b < 4; b++)
          if (strb_q[b]) regs_q[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[32*k +: 32] = regs_q[k];
  end

  assign hrdata_o = ((state_q == S_DATA) && !write_q) ? regs_q[idx_q] : 32'd0;

endmodule

// File: tb/tb_ahb3_lite_regfile_slave.sv
// Directed bench for the AHB3-Lite register-file slave: one instance without
// wait states and one with two wait states, each acting as the only slave.
module tb_ahb3_lite_regfile_slave;
  import ahb3_lite_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  haddr;
  logic [2:0]   hburst, hsize;
  logic [1:0]   htrans;
  logic [31:0]  hwdata;
  logic         hwrite, hsel0, hsel2;

  logic [31:0]  hrdata0, hrdata2;
  logic         hreadyout0, hreadyout2, hresp0, hresp2;
  logic [255:0] regs0, regs2;
  logic [7:0]   wrp0, wrp2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ahb3_lite_regfile_slave #(.ADDR_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .haddr_i(haddr), .hburst_i(hburst), .hsize_i(hsize),
    .htrans_i(htrans), .hwdata_i(hwdata), .hwrite_i(hwrite), .hsel_i(hsel0),
    .hready_i(hreadyout0), .hrdata_o(hrdata0), .hreadyout_o(hreadyout0),
    .hresp_o(hresp0), .regs_o(regs0), .wr_pulse_o(wrp0)
  );

  ahb3_lite_regfile_slave #(.ADDR_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .haddr_i(haddr), .hburst_i(hburst), .hsize_i(hsize),
    .htrans_i(htrans), .hwdata_i(hwdata), .hwrite_i(hwrite), .hsel_i(hsel2),
    .hready_i(hreadyout2), .hrdata_o(hrdata2), .hreadyout_o(hreadyout2),
    .hresp_o(hresp2), .regs_o(regs2), .wr_pulse_o(wrp2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [31:0] a, input logic [2:0] s, input logic w, input logic [1:0] t);
    haddr  = a;
    hsize  = s;
    hwrite = w;
    htrans = t;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    hsel0 = 1'b0; hsel2 = 1'b0; haddr = 32'd0; hburst = HBURST_SINGLE;
    hsize = HSIZE_WORD; htrans = HTRANS_IDLE; hwdata = 32'd0; hwrite = 1'b0;
    step; step;
    checks++; if (hreadyout0 !== 1'b1) $display("FAIL reset_ready: got %b expected 1", hreadyout0); else passed++;
    checks++; if (hresp0 !== 1'b0) $display("FAIL reset_resp: got %b expected 0", hresp0); else passed++;
    checks++; if (hrdata0 !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", hrdata0); else passed++;
    checks++; if (wrp0 !== 8'd0) $display("FAIL reset_pulse: got %h expected 00", wrp0); else passed++;
    checks++; if (regs0 !== 256'd0) $display("FAIL reset_regs: got %h expected 0", regs0); else passed++;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_word_rw;
    hsel0 = 1'b1;
    ap(32'h0, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    step;
    hwdata = 32'hDEADBEEF;
    ap(32'h0, HSIZE_WORD, 1'b0, HTRANS_NONSEQ);
    checks++; if (hreadyout0 !== 1'b1) $display("FAIL wr_ready: got %b expected 1", hreadyout0); else passed++;
    checks++; if (hrdata0 !== 32'd0) $display("FAIL wr_phase_rdata: got %h expected 0", hrdata0); else passed++;
    step;
    htrans = HTRANS_IDLE;
    checks++; if (hrdata0 !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", hrdata0); else passed++;
    checks++; if (hresp0 !== 1'b0) $display("FAIL rd_resp: got %b expected 0", hresp0); else passed++;
    checks++; if (wrp0 !== 8'h01) $display("FAIL wr_pulse: got %h expected 01", wrp0); else passed++;
    step;
    checks++; if (wrp0 !== 8'h00) $display("FAIL wr_pulse_once: got %h expected 00", wrp0); else passed++;
    checks++; if (hrdata0 !== 32'd0) $display("FAIL idle_rdata: got %h expected 0", hrdata0); else passed++;
    checks++; if (regs0[31:0] !== 32'hDEADBEEF) $display("FAIL reg0_word: got %h expected deadbeef", regs0[31:0]); else passed++;
  endtask

  task automatic test_lanes;
    hsel0 = 1'b1;
    ap(32'h4, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    step;
    hwdata = 32'h11223344;
    ap(32'h5, HSIZE_BYTE, 1'b1, HTRANS_NONSEQ);
    step;
    hwdata = 32'h0000AB00;
    ap(32'h6, HSIZE_HALF, 1'b1, HTRANS_NONSEQ);
    checks++; if (regs0[63:32] !== 32'h11223344) $display("FAIL reg1_word: got %h expected 11223344", regs0[63:32]); else passed++;
    step;
    hwdata = 32'hCAFE0000;
    htrans = HTRANS_IDLE;
    checks++; if (regs0[63:32] !== 32'h1122AB44) $display("FAIL reg1_byte: got %h expected 1122ab44", regs0[63:32]); else passed++;
    step;
    checks++; if (regs0[63:32] !== 32'hCAFEAB44) $display("FAIL reg1_half: got %h expected cafeab44", regs0[63:32]); else passed++;
    checks++; if (wrp0 !== 8'h02) $display("FAIL reg1_pulse: got %h expected 02", wrp0); else passed++;
  endtask

  task automatic test_error;
    logic [255:0] exp_regs;
    exp_regs = {192'd0, 32'hCAFEAB44, 32'hDEADBEEF};
    hsel0 = 1'b1;
    ap(32'h20, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    step;
    hwdata = 32'hFFFFFFFF;
    htrans = HTRANS_IDLE;
    checks++; if ({hreadyout0, hresp0} !== 2'b01) $display("FAIL oob_err1: got %b expected 01", {hreadyout0, hresp0}); else passed++;
    step;
    checks++; if ({hreadyout0, hresp0} !== 2'b11) $display("FAIL oob_err2: got %b expected 11", {hreadyout0, hresp0}); else passed++;
    ap(32'h1, HSIZE_HALF, 1'b1, HTRANS_NONSEQ);
    step;
    htrans = HTRANS_IDLE;
    checks++; if ({hreadyout0, hresp0} !== 2'b01) $display("FAIL mis_err1: got %b expected 01", {hreadyout0, hresp0}); else passed++;
    step;
    checks++; if ({hreadyout0, hresp0} !== 2'b11) $display("FAIL mis_err2: got %b expected 11", {hreadyout0, hresp0}); else passed++;
    step;
    checks++; if ({hreadyout0, hresp0} !== 2'b10) $display("FAIL err_recover: got %b expected 10", {hreadyout0, hresp0}); else passed++;
    checks++; if (regs0 !== exp_regs) $display("FAIL err_regs: got %h expected %h", regs0, exp_regs); else passed++;
    checks++; if (wrp0 !== 8'h00) $display("FAIL err_pulse: got %h expected 00", wrp0); else passed++;
  endtask

  task automatic test_burst_pipelined_read;
    hsel0  = 1'b1;
    hburst = HBURST_INCR4;
    ap(32'h0, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    step;
    for (int i = 1; i <= 4; i++) begin
      hwdata = 32'(i);
      if (i < 4) begin
        haddr  = 32'(4 * i);
        htrans = HTRANS_SEQ;
      end else begin
        hburst = HBURST_SINGLE;
        ap(32'h8, HSIZE_WORD, 1'b0, HTRANS_NONSEQ);
      end
      checks++; if (hreadyout0 !== 1'b1) $display("FAIL burst_ready_beat%0d: got %b expected 1", i, hreadyout0); else passed++;
      step;
    end
    htrans = HTRANS_IDLE;
    checks++; if (hrdata0 !== 32'd3) $display("FAIL burst_read: got %h expected 3", hrdata0); else passed++;
    checks++; if (hreadyout0 !== 1'b1) $display("FAIL burst_read_ready: got %b expected 1", hreadyout0); else passed++;
    step;
    checks++; if (regs0[127:0] !== {32'd4, 32'd3, 32'd2, 32'd1}) $display("FAIL burst_regs: got %h expected 4/3/2/1", regs0[127:0]); else passed++;
  endtask

  task automatic test_back_to_back_wait;
    int lows;
    hsel0 = 1'b0;
    hsel2 = 1'b1;
    ap(32'h0, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    step;
    hwdata = 32'hA5A5A5A5;
    ap(32'h4, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    lows = 0;
    while (hreadyout2 == 1'b0 && lows < 20) begin lows++; step; end
    checks++; if (lows !== 2) $display("FAIL wait_beat1: got %0d low cycles expected 2", lows); else passed++;
    step;
    hwdata = 32'h5A5A5A5A;
    htrans = HTRANS_IDLE;
    lows = 0;
    while (hreadyout2 == 1'b0 && lows < 20) begin lows++; step; end
    checks++; if (lows !== 2) $display("FAIL wait_beat2: got %0d low cycles expected 2", lows); else passed++;
    checks++; if (regs2[31:0] !== 32'hA5A5A5A5) $display("FAIL wait_reg0: got %h expected a5a5a5a5", regs2[31:0]); else passed++;
    step;
    checks++; if (regs2[63:32] !== 32'h5A5A5A5A) $display("FAIL wait_reg1: got %h expected 5a5a5a5a", regs2[63:32]); else passed++;
    checks++; if (wrp2 !== 8'h02) $display("FAIL wait_pulse: got %h expected 02", wrp2); else passed++;
  endtask

  task automatic test_reset_mid_wait;
    hsel2 = 1'b1;
    ap(32'h8, HSIZE_WORD, 1'b1, HTRANS_NONSEQ);
    step;
    hwdata = 32'hFFFFFFFF;
    htrans = HTRANS_IDLE;
    checks++; if (hreadyout2 !== 1'b0) $display("FAIL mid_in_wait: got %b expected 0", hreadyout2); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({hreadyout2, hresp2} !== 2'b10) $display("FAIL mid_rst_outputs: got %b expected 10", {hreadyout2, hresp2}); else passed++;
    checks++; if (regs2 !== 256'd0) $display("FAIL mid_rst_regs: got %h expected 0", regs2); else passed++;
    checks++; if (wrp2 !== 8'd0) $display("FAIL mid_rst_pulse: got %h expected 00", wrp2); else passed++;
    step;
    rst_n = 1'b1;
    repeat (4) step;
    checks++; if (regs2[95:64] !== 32'd0) $display("FAIL mid_rst_target: got %h expected 0", regs2[95:64]); else passed++;
    checks++; if (hreadyout2 !== 1'b1) $display("FAIL mid_rst_idle: got %b expected 1", hreadyout2); else passed++;
  endtask

  initial begin
    test_reset;
    test_word_rw;
    test_lanes;
    test_error;
    test_burst_pipelined_read;
    test_back_to_back_wait;
    test_reset_mid_wait;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
